// File: rtl/lstm_cell_update_pkg.sv
// Shared fixed-point types, gate layout and Q-format arithmetic helpers for the LSTM cell update.
// All helpers take the fractional bit count so the datapath can be re-pointed at another Q format.
package lstm_pkg;

  typedef logic signed [31:0] fix_t;

  localparam int   FRAC_BITS = 16;
  localparam fix_t FIX_ONE   = 32'sh0001_0000;
  localparam fix_t FIX_HALF  = 32'sh0000_8000;

  // Gate order inside the 4N pre-activation vector.
  typedef enum logic [1:0] {
    GATE_I = 2'd0,
    GATE_F = 2'd1,
    GATE_G = 2'd2,
    GATE_O = 2'd3
  } gate_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int gate_base(input gate_e g, input int n);
    return int'(g) * n;
  endfunction

  function automatic fix_t fx_one(input int frac);
    return fix_t'(1) <<< frac;
  endfunction

  // Low 64 bits of a product are identical for signed and unsigned operands,
  // so sign-extend by hand and let the arithmetic shift floor the result.
  function automatic fix_t fxmul(input fix_t a, input fix_t b, input int frac);
    logic signed [63:0] prod;
    prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    return fix_t'(prod >>> frac);
  endfunction

  function automatic fix_t fx_hsig(input fix_t x, input int frac);
    fix_t t;
    t = (x >>> 2) + (fix_t'(1) <<< (frac - 1));
    if (t < 0)
      return '0;
    else if (t > fx_one(frac))
      return fx_one(frac);
    else
      return t;
  endfunction

  function automatic fix_t fx_htanh(input fix_t x, input int frac);
    if (x > fx_one(frac))
      return fx_one(frac);
    else if (x < -fx_one(frac))
      return -fx_one(frac);
    else
      return x;
  endfunction

endpackage

// File: rtl/lstm_cell_update_act.sv
// Four-lane combinational activation unit feeding stage 1: hard sigmoid on the
// i, f, o lanes and hard tanh on the g lane.
module lstm_act_unit
  import lstm_pkg::*;
#(
  parameter int FRAC = FRAC_BITS
) (
  input  logic signed [31:0] a_i,
  input  logic signed [31:0] a_f,
  input  logic signed [31:0] a_g,
  input  logic signed [31:0] a_o,
  output logic signed [31:0] act_i,
  output logic signed [31:0] act_f,
  output logic signed [31:0] act_g,
  output logic signed [31:0] act_o
);

  always_comb begin
    act_i = fx_hsig(a_i, FRAC);
    act_f = fx_hsig(a_f, FRAC);
    act_g = fx_htanh(a_g, FRAC);
    act_o = fx_hsig(a_o, FRAC);
  end

endmodule

// File: rtl/lstm_cell_update.sv
// Serial LSTM cell update: one element per cycle through activation/product and
// cell/hidden stages. Define LSTM_CELL_SAT_EN to saturate the cell sum instead of wrapping.
module lstm_cell_update
  import lstm_pkg::*;
#(
  parameter int N    = 100,
  parameter int FRAC = FRAC_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] a_in   [0:4*N-1],
  input  logic signed [31:0] c_prev [0:N-1],
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] h_out  [0:N-1],
  output logic signed [31:0] c_out  [0:N-1]
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int AW    = $clog2(4 * N);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               drain_q, drain_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  fix_t               a_q   [0:4*N-1];
  fix_t               a_d   [0:4*N-1];
  fix_t               cp_q  [0:N-1];
  fix_t               cp_d  [0:N-1];

  logic               s1_vld_q, s1_vld_d;
  logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
  fix_t               s1_o_q, s1_o_d;
  fix_t               s1_pf_q, s1_pf_d;
  fix_t               s1_pi_q, s1_pi_d;

  logic               s2_vld_q, s2_vld_d;
  logic [IDX_W-1:0]   s2_idx_q, s2_idx_d;
  fix_t               s2_c_q, s2_c_d;
  fix_t               s2_h_q, s2_h_d;

  fix_t               h_out_q [0:N-1];
  fix_t               h_out_d [0:N-1];
  fix_t               c_out_q [0:N-1];
  fix_t               c_out_d [0:N-1];

  fix_t               lane_i, lane_f, lane_g, lane_o, lane_cp;
  fix_t               act_i, act_f, act_g, act_o;
  logic signed [32:0] c_sum;
  fix_t               c_new;

  // Operand fetch for the element currently issued from the latched vectors.
  always_comb begin
    lane_i  = a_q[AW'(gate_base(GATE_I, N) + int'(idx_q))];
    lane_f  = a_q[AW'(gate_base(GATE_F, N) + int'(idx_q))];
    lane_g  = a_q[AW'(gate_base(GATE_G, N) + int'(idx_q))];
    lane_o  = a_q[AW'(gate_base(GATE_O, N) + int'(idx_q))];
    lane_cp = cp_q[idx_q];
  end

  lstm_act_unit #(.FRAC(FRAC)) u_act (
    .a_i   (lane_i),
    .a_f   (lane_f),
    .a_g   (lane_g),
    .a_o   (lane_o),
    .act_i (act_i),
    .act_f (act_f),
    .act_g (act_g),
    .act_o (act_o)
  );

  // Cell sum is formed one bit wider so overflow is visible before reduction.
  always_comb begin
    c_sum = {s1_pf_q[31], s1_pf_q} + {s1_pi_q[31], s1_pi_q};
`ifdef LSTM_CELL_SAT_EN
    if (c_sum[32] != c_sum[31])
      c_new = c_sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    else
      c_new = c_sum[31:0];
`else
    c_new = c_sum[31:0];
`endif
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    a_d      = a_q;
    cp_d     = cp_q;

    s1_vld_d = 1'b0;
    s1_idx_d = idx_q;
    s1_o_d   = act_o;
    s1_pf_d  = fxmul(act_f, lane_cp, FRAC);
    s1_pi_d  = fxmul(act_i, act_g, FRAC);

    s2_vld_d = s1_vld_q;
    s2_idx_d = s1_idx_q;
    s2_c_d   = c_new;
    s2_h_d   = fxmul(s1_o_q, fx_htanh(c_new, FRAC), FRAC);

    h_out_d  = h_out_q;
    c_out_d  = c_out_q;
    if (s2_vld_q) begin
      h_out_d[s2_idx_q] = s2_h_q;
      c_out_d[s2_idx_q] = s2_c_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          cp_d    = c_prev;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        s1_vld_d = 1'b1;
        if (idx_q == IDX_W'(N - 1)) begin
          drain_d = 1'b0;
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q)
          state_d = ST_DONE;
        else
          drain_d = 1'b1;
      end
      ST_DONE: begin
        if (out_valid_q && out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The last element lands on the DONE entry edge, so valid follows one cycle later.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_q == ST_DONE) && (state_d == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      drain_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      h_out_q     <= '{default: '0};
      c_out_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      drain_q     <= drain_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      s1_vld_q    <= s1_vld_d;
      s2_vld_q    <= s2_vld_d;
      h_out_q     <= h_out_d;
      c_out_q     <= c_out_d;
    end
  end

  // NOTE: the input latches and pipeline payloads carry no reset; they are always
  // written before being consumed, and only the visible result arrays must read zero.
  always_ff @(posedge clk) begin
    a_q      <= a_d;
    cp_q     <= cp_d;
    s1_idx_q <= s1_idx_d;
    s1_o_q   <= s1_o_d;
    s1_pf_q  <= s1_pf_d;
    s1_pi_q  <= s1_pi_d;
    s2_idx_q <= s2_idx_d;
    s2_c_q   <= s2_c_d;
    s2_h_q   <= s2_h_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign h_out     = h_out_q;
  assign c_out     = c_out_q;

endmodule
